// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issue stage for the 8-bit combinational ALU.
// Registers a command onto the ALU inputs, waits HOLD_CYCLES for the ALU to
// settle, captures result/carry into the result port and the accumulator.
// Optional build macro: ALU_SEQ_FLAGS_EN adds res_zero, carry_sticky and sticky_clr.
//
// state  | meaning
// IDLE   | ready for a command; ALU inputs hold the last command
// SETTLE | ALU inputs stable, settle counter running down to zero
// RESP   | result captured, waiting for the consumer to take it
module alu_cmd_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic [7:0] acc
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic       res_zero,
    output logic       carry_sticky,
    input  logic       sticky_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;

    // cmd_ready is held low while reset is asserted, otherwise follows IDLE
    assign cmd_ready = (state == IDLE) && !rst;
    assign res_valid = (state == RESP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and per-cycle strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operand/opcode registers, loaded only on command accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= 8'd0;
            alu_b   <= 8'd0;
            alu_sel <= 4'd0;
        end else if (accept) begin
            alu_a   <= cmd_use_acc ? acc : cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_op;
        end
    end

    // Settle down-counter; terminal count zero triggers capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  cnt <= 4'd0;
        else if (accept)                          cnt <= CNT_LOAD;
        else if (state == SETTLE && cnt != 4'd0)  cnt <= cnt - 4'd1;
    end

    // Result and accumulator capture; carry never feeds the accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data  <= 8'd0;
            res_carry <= 1'b0;
            acc       <= 8'd0;
        end else if (capture) begin
            res_data  <= alu_out;
            res_carry <= alu_carry;
            acc       <= alu_out;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Zero flag captured with the result; sticky carry where set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_zero     <= 1'b0;
            carry_sticky <= 1'b0;
        end else begin
            if (capture) res_zero <= (alu_out == 8'd0);
            if (capture && alu_carry) carry_sticky <= 1'b1;
            else if (sticky_clr)      carry_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream issue stage for the team's 8-bit combinational ALU. Accepts operation commands over a valid/ready handshake and drives registered operands and opcode into the ALU. After a programmable settle time it captures the ALU result and carry-out, and presents them on a valid/ready result port. An internal accumulator holds the last result and can be selected as operand A, so multi-step arithmetic can be chained without a round trip through the host.

## Interface

Parameters:
- HOLD_CYCLES, 1: cycles operands are held stable on the ALU before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  ALU opcode, passed unmodified to alu_sel
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_use_acc  in  1  1: operand A is taken from the accumulator; cmd_a is ignored
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_sel  out  4  registered opcode to ALU
- alu_out  in  8  ALU result
- alu_carry  in  1  ALU carry-out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  captured result
- res_carry  out  1  captured carry-out
- acc  out  8  accumulator contents

## Operation

- FSM states: IDLE, SETTLE, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: load alu_a, alu_b, alu_sel.
    - alu_a = cmd_use_acc ? acc : cmd_a.
    - Load the settle counter with HOLD_CYCLES-1.
    - Go to SETTLE.
- SETTLE:
  - cmd_ready=0.
  - If the counter is non-zero, decrement it.
  - If the counter is zero:
    - Capture res_data<=alu_out, res_carry<=alu_carry, acc<=alu_out.
    - Set res_valid=1 and go to RESP.
- RESP:
  - cmd_ready=0.
  - res_valid, res_data and res_carry are held stable until res_valid&&res_ready.
  - On res_valid&&res_ready, clear res_valid and go to IDLE.
- alu_a, alu_b and alu_sel keep their last values outside SETTLE; they change only on command accept.
- Accumulator: 8-bit, updated only on capture, never wraps beyond 8 bits. The ALU carry goes to res_carry only, never into acc.
- Reset values: cmd_ready=0 while rst is high, then 1 in IDLE. alu_a=0, alu_b=0, alu_sel=0, res_valid=0, res_data=0, res_carry=0, acc=0, counter=0.
- Reset asserted in SETTLE or RESP aborts the command: no result is delivered and the accumulator returns to 0.
- cmd_valid while cmd_ready=0 is ignored. The upstream must hold the command until it is accepted.
- Data on cmd_* is sampled only at the accept edge.

## Timing

- Accept edge E0: alu_* are valid after E0.
- Capture edge: E0+HOLD_CYCLES. res_valid rises after this edge.
- Result is handed off at the first edge with res_ready=1 after res_valid rises (earliest E0+HOLD_CYCLES+1). cmd_ready rises after that edge.
- Minimum command period: HOLD_CYCLES+2 cycles.
- Chained command (cmd_use_acc=1) accepted in IDLE always sees the acc value from the previous capture.
- No combinational path from cmd_valid to cmd_ready, or from res_ready to res_valid.

## Configuration

- ALU_SEQ_FLAGS_EN defined: adds two outputs and one input.
  - res_zero (out, 1): captured alongside res_data; 1 when alu_out==0.
  - carry_sticky (out, 1): set on any capture with alu_carry=1.
  - sticky_clr (in, 1): clears carry_sticky synchronously.
  - If sticky_clr coincides with a capture with carry, carry_sticky ends at 1 (set wins).
  - Both outputs reset to 0.
- ALU_SEQ_FLAGS_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan

The bench drives the team's 8-bit ALU with opcode 0x0=add and 0x1=sub, HOLD_CYCLES=1 unless stated.

- Basic add: cmd a=0x0A, b=0x02, op=0x0, res_ready=1 -> res_data=0x0C, res_carry=0, acc=0x0C; res_valid one cycle after the capture edge E0+1.
- Carry-out: a=0xF6, b=0x0A, op=0x0 -> res_data=0x00, res_carry=1, acc=0x00; with flags enabled, res_zero=1 and carry_sticky=1.
- Chaining: after the basic add, send cmd_use_acc=1, cmd_a=0xFF, b=0x02, op=0x1 -> alu_a=0x0C, res_data=0x0A.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_valid, res_data and res_carry stay stable and cmd_ready=0 throughout; handoff on the first res_ready=1; a new cmd_valid is ignored until cmd_ready=1.
- Settle count: HOLD_CYCLES=4 -> capture at E0+4; alu_a/alu_b/alu_sel are unchanged over those 4 cycles.
- Reset mid-operation: assert rst during SETTLE -> all outputs return to reset values immediately, res_valid never asserts, and acc=0.
